// File: rtl/multi_edge_detector.sv
// multi_edge_detector
// N independent input channels. Each channel passes through a flop-chain
// synchroniser, then a consecutive-sample debounce filter, and produces a
// registered debounced level plus one-cycle rising/falling pulses.
// any_edge is a registered OR of every pulse, aligned with the pulses.
//
// Optional feature: define EDGE_LATCH_EN to add per-channel sticky edge
// flags (event_flags) with a per-channel clear (event_clear). Without it,
// event_flags is tied to 0 and event_clear is ignored.
module multi_edge_detector #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal_in,
    output logic [CHANNELS-1:0] signal_out,
    output logic [CHANNELS-1:0] rising_edge,
    output logic [CHANNELS-1:0] falling_edge,
    output logic                any_edge,
    input  logic [CHANNELS-1:0] event_clear,
    output logic [CHANNELS-1:0] event_flags
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
    logic [CW-1:0]          r_cnt  [CHANNELS];
    logic [CHANNELS-1:0]    r_level;
    logic [CHANNELS-1:0]    r_rise;
    logic [CHANNELS-1:0]    r_fall;
    logic                   r_any;

    logic [CW-1:0]          w_cnt_nxt [CHANNELS];
    logic [CHANNELS-1:0]    w_sync;
    logic [CHANNELS-1:0]    w_mismatch;
    logic [CHANNELS-1:0]    w_accept;
    logic [CHANNELS-1:0]    w_level_nxt;
    logic [CHANNELS-1:0]    w_rise_nxt;
    logic [CHANNELS-1:0]    w_fall_nxt;

    // Shift each raw input through its synchroniser chain; the MSB is the safe sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], signal_in[i]};
            end
        end
    end

    // Debounce decision: accept a new level once the mismatch has persisted long enough.
    always_comb begin
        w_sync      = '0;
        w_mismatch  = '0;
        w_accept    = '0;
        w_level_nxt = r_level;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cnt_nxt[i]  = '0;
            w_sync[i]     = r_sync[i][SYNC_STAGES-1];
            w_mismatch[i] = w_sync[i] ^ r_level[i];
            w_accept[i]   = w_mismatch[i] && (r_cnt[i] == CNT_MAX);
            if (w_accept[i]) begin
                // Counter returns to 0 on acceptance so it can never wrap.
                w_cnt_nxt[i]   = '0;
                w_level_nxt[i] = w_sync[i];
                w_rise_nxt[i]  = w_sync[i];
                w_fall_nxt[i]  = ~w_sync[i];
            end else if (w_mismatch[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    // Register debounce counters, stable levels and the one-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            r_any   <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            // Built from next-state pulses so it lands in the same cycle as them.
            r_any   <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign signal_out   = r_level;
    assign rising_edge  = r_rise;
    assign falling_edge = r_fall;
    assign any_edge     = r_any;

`ifdef EDGE_LATCH_EN
    logic [CHANNELS-1:0] r_flags;

    // Sticky flags: a pulse sets, clear drops, and a set in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_rise | r_fall) | (r_flags & ~event_clear);
        end
    end

    assign event_flags = r_flags;
`else
    // Clear input has no effect without the flag registers.
    logic w_unused_clear;
    assign w_unused_clear = ^event_clear;
    assign event_flags    = '0;
`endif

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed self-checking bench for multi_edge_detector (default parameters).
// Inputs change 1 ns after a rising clk edge; outputs are sampled there too.
module tb_multi_edge_detector;

    logic       clk;
    logic       rst_n;
    logic [3:0] signal_in;
    logic [3:0] signal_out;
    logic [3:0] rising_edge;
    logic [3:0] falling_edge;
    logic       any_edge;
    logic [3:0] event_clear;
    logic [3:0] event_flags;

    int checks = 0;
    int errors = 0;

    multi_edge_detector #(
        .CHANNELS       (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal_in   (signal_in),
        .signal_out  (signal_out),
        .rising_edge (rising_edge),
        .falling_edge(falling_edge),
        .any_edge    (any_edge),
        .event_clear (event_clear),
        .event_flags (event_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        signal_in   = 4'b0000;
        event_clear = 4'b0000;
        #3;
        checks++;
        if ({signal_out, rising_edge, falling_edge, any_edge, event_flags} !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got out=%b r=%b f=%b any=%b flg=%b want all 0",
                     signal_out, rising_edge, falling_edge, any_edge, event_flags);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({signal_out, rising_edge, falling_edge, any_edge, event_flags} !== 17'd0) begin
                errors++;
                $display("FAIL idle_zero cyc=%0d got out=%b r=%b f=%b any=%b flg=%b want all 0",
                         k, signal_out, rising_edge, falling_edge, any_edge, event_flags);
            end
        end
    endtask

    // Channel 0 rises then falls; each transition lands on the 6th edge after capture.
    task automatic test_single_edge();
        logic [3:0] exp_out, exp_r, exp_f;
        logic       exp_any;
        signal_in = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_out = (k >= 6) ? 4'b0001 : 4'b0000;
            exp_r   = (k == 6) ? 4'b0001 : 4'b0000;
            exp_any = (k == 6);
            checks++;
            if (signal_out !== exp_out || rising_edge !== exp_r || falling_edge !== 4'b0000 ||
                any_edge !== exp_any) begin
                errors++;
                $display("FAIL rise0 cyc=%0d got out=%b r=%b f=%b any=%b want out=%b r=%b f=0000 any=%b",
                         k, signal_out, rising_edge, falling_edge, any_edge, exp_out, exp_r, exp_any);
            end
        end
        signal_in = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_out = (k >= 6) ? 4'b0000 : 4'b0001;
            exp_f   = (k == 6) ? 4'b0001 : 4'b0000;
            exp_any = (k == 6);
            checks++;
            if (signal_out !== exp_out || falling_edge !== exp_f || rising_edge !== 4'b0000 ||
                any_edge !== exp_any) begin
                errors++;
                $display("FAIL fall0 cyc=%0d got out=%b r=%b f=%b any=%b want out=%b r=0000 f=%b any=%b",
                         k, signal_out, rising_edge, falling_edge, any_edge, exp_out, exp_f, exp_any);
            end
        end
    endtask

    // 3-sample glitch is rejected; 4-sample pulse passes as rise then fall.
    task automatic test_glitch();
        int rise_cnt, fall_cnt, rise_at, fall_at;
        signal_in = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) signal_in = 4'b0000;
            checks++;
            if (signal_out !== 4'b0000 || rising_edge !== 4'b0000 || falling_edge !== 4'b0000 ||
                any_edge !== 1'b0) begin
                errors++;
                $display("FAIL glitch3 cyc=%0d got out=%b r=%b f=%b any=%b want all 0",
                         k, signal_out, rising_edge, falling_edge, any_edge);
            end
        end
        rise_cnt = 0; fall_cnt = 0; rise_at = 0; fall_at = 0;
        signal_in = 4'b0010;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 4) signal_in = 4'b0000;
            if (rising_edge[1] === 1'b1) begin rise_cnt++; rise_at = k; end
            if (falling_edge[1] === 1'b1) begin fall_cnt++; fall_at = k; end
            if (k == 7) begin
                checks++;
                if (signal_out !== 4'b0010) begin
                    errors++;
                    $display("FAIL pulse4_level got %b want 0010", signal_out);
                end
            end
        end
        checks++;
        if (rise_cnt !== 1 || rise_at !== 6) begin
            errors++;
            $display("FAIL pulse4_rise got count=%0d at=%0d want count=1 at=6", rise_cnt, rise_at);
        end
        checks++;
        if (fall_cnt !== 1 || fall_at !== 10) begin
            errors++;
            $display("FAIL pulse4_fall got count=%0d at=%0d want count=1 at=10", fall_cnt, fall_at);
        end
        checks++;
        if (signal_out !== 4'b0000) begin
            errors++;
            $display("FAIL pulse4_final got %b want 0000", signal_out);
        end
    endtask

    // All channels switch together: one shared pulse cycle, any_edge exactly once.
    task automatic test_all_channels();
        int any_cnt;
        any_cnt = 0;
        signal_in = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (any_edge === 1'b1) any_cnt++;
            if (k == 6) begin
                checks++;
                if (rising_edge !== 4'b1111 || falling_edge !== 4'b0000 || signal_out !== 4'b1111) begin
                    errors++;
                    $display("FAIL all_rise got r=%b f=%b out=%b want r=1111 f=0000 out=1111",
                             rising_edge, falling_edge, signal_out);
                end
            end
        end
        checks++;
        if (any_cnt !== 1) begin
            errors++;
            $display("FAIL all_rise_any got %0d pulses want 1", any_cnt);
        end
        any_cnt = 0;
        signal_in = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (any_edge === 1'b1) any_cnt++;
            if (k == 6) begin
                checks++;
                if (falling_edge !== 4'b1111 || rising_edge !== 4'b0000 || signal_out !== 4'b0000) begin
                    errors++;
                    $display("FAIL all_fall got r=%b f=%b out=%b want r=0000 f=1111 out=0000",
                             rising_edge, falling_edge, signal_out);
                end
            end
        end
        checks++;
        if (any_cnt !== 1) begin
            errors++;
            $display("FAIL all_fall_any got %0d pulses want 1", any_cnt);
        end
    endtask

    // Reset mid-debounce on channel 2 clears everything at once; re-detect after release.
    task automatic test_async_reset();
        signal_in = 4'b0001;
        repeat (8) tick();
        checks++;
        if (signal_out !== 4'b0001) begin
            errors++;
            $display("FAIL arst_setup got %b want 0001", signal_out);
        end
        signal_in = 4'b0101;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({signal_out, rising_edge, falling_edge, any_edge, event_flags} !== 17'd0) begin
            errors++;
            $display("FAIL arst_immediate got out=%b r=%b f=%b any=%b flg=%b want all 0",
                     signal_out, rising_edge, falling_edge, any_edge, event_flags);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (rising_edge !== ((k == 6) ? 4'b0101 : 4'b0000) ||
                signal_out !== ((k >= 6) ? 4'b0101 : 4'b0000)) begin
                errors++;
                $display("FAIL arst_relatch cyc=%0d got r=%b out=%b want r=%b out=%b", k,
                         rising_edge, signal_out, (k == 6) ? 4'b0101 : 4'b0000,
                         (k >= 6) ? 4'b0101 : 4'b0000);
            end
        end
        signal_in = 4'b0000;
        repeat (8) tick();
    endtask

`ifdef EDGE_LATCH_EN
    task automatic test_edge_latch();
        signal_in = 4'b1000;
        repeat (7) tick();
        checks++;
        if (event_flags !== 4'b1000) begin
            errors++;
            $display("FAIL latch_set got %b want 1000", event_flags);
        end
        repeat (3) tick();
        checks++;
        if (event_flags !== 4'b1000) begin
            errors++;
            $display("FAIL latch_hold got %b want 1000", event_flags);
        end
        signal_in = 4'b0000;
        repeat (8) tick();
        event_clear = 4'b1000;
        tick();
        event_clear = 4'b0000;
        checks++;
        if (event_flags !== 4'b0000) begin
            errors++;
            $display("FAIL latch_clear got %b want 0000", event_flags);
        end
        signal_in = 4'b1000;
        repeat (6) tick();
        checks++;
        if (rising_edge !== 4'b1000) begin
            errors++;
            $display("FAIL latch_rise2 got %b want 1000", rising_edge);
        end
        event_clear = 4'b1000;
        tick();
        event_clear = 4'b0000;
        checks++;
        if (event_flags !== 4'b1000) begin
            errors++;
            $display("FAIL latch_set_wins got %b want 1000", event_flags);
        end
        tick();
        event_clear = 4'b1000;
        tick();
        event_clear = 4'b0000;
        checks++;
        if (event_flags !== 4'b0000) begin
            errors++;
            $display("FAIL latch_idle_clear got %b want 0000", event_flags);
        end
    endtask
`else
    task automatic test_edge_latch();
        event_clear = 4'b1111;
        signal_in   = 4'b1000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (event_flags !== 4'b0000) begin
                errors++;
                $display("FAIL flags_tied cyc=%0d got %b want 0000", k, event_flags);
            end
        end
        event_clear = 4'b0000;
        checks++;
        if (signal_out !== 4'b1000) begin
            errors++;
            $display("FAIL flags_ch3_level got %b want 1000", signal_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_edge();
        test_glitch();
        test_all_channels();
        test_async_reset();
        test_edge_latch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised successor to the single-bit edge detector: N independent channels, each with a metastability synchroniser, a consecutive-sample debounce filter and registered one-cycle rising/falling pulses.
- Sits between raw asynchronous inputs (buttons, switches, external strobes) and the FSM/control logic.
- Per-channel debounced level is also output.

Parameters:
- CHANNELS, 4: number of independent input channels, >=1.
- SYNC_STAGES, 2: synchroniser flip-flops per channel, >=2.
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples differing from the stable level required to accept a change, >=1; 1 = no filtering.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- signal_in  in  CHANNELS  raw asynchronous inputs; bit i = channel i.
- signal_out  out  CHANNELS  debounced stable level per channel.
- rising_edge  out  CHANNELS  one-cycle pulse when signal_out bit goes 0->1.
- falling_edge  out  CHANNELS  one-cycle pulse when signal_out bit goes 1->0.
- any_edge  out  1  OR of all rising_edge and falling_edge bits, same cycle.
- event_clear  in  CHANNELS  sticky-flag clear, only with EDGE_LATCH_EN; otherwise ignored/unconnected.
- event_flags  out  CHANNELS  sticky edge flags, only with EDGE_LATCH_EN; otherwise tied 0.

Behaviour:
- Interface: one clock, clk; reset rst_n, asynchronous and active-low.
- Reset (rst_n=0, asynchronous): all synchroniser stages, debounce counters, signal_out, rising_edge, falling_edge, any_edge and event_flags = 0 immediately. Reset asserted mid-debounce discards the partial count; no pulse is produced.
- Outputs are all registered. No combinational path from signal_in to any output (the original design's combinational edge outputs are not carried over).
- Synchroniser: per-channel shift chain of SYNC_STAGES flops; sync = last stage.
- Debounce, per channel, per clock:
  - sync == signal_out: counter <= 0.
  - sync != signal_out and counter == DEBOUNCE_CYCLES-1: signal_out <= sync, counter <= 0, corresponding edge pulse <= 1.
  - Otherwise: counter <= counter+1.
  - Counter width = clog2(DEBOUNCE_CYCLES), minimum 1 bit. The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Latency: signal_in changes before edge E0 and then holds. signal_out and the pulse take effect at edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1. Defaults: 6 edges from first capture to output.
- Glitch rejection: a mismatch run shorter than DEBOUNCE_CYCLES resets the counter; signal_out is unchanged and no pulse occurs.
- rising_edge/falling_edge: high exactly one cycle, cleared the next edge. Never both high on the same channel.
- Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle. any_edge is a single registered OR.
- Post-reset input held 1: treated as a real 0->1 transition and produces a rising_edge after full latency.

Optional Feature:
- Macro: EDGE_LATCH_EN.
- Defined:
  - event_flags[i] sets on any rising_edge[i] or falling_edge[i] pulse and holds until event_clear[i]=1 at a clock edge.
  - Set and clear in the same cycle: set wins, flag stays 1.
  - Reset value 0.
- Undefined: event_flags driven constant 0, event_clear ignored, no flag registers synthesised.

Test Plan (defaults CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset then hold signal_in=4'b0000 for 20 cycles -> all outputs 0 throughout.
- signal_in[0] 0->1 held -> signal_out[0]=1 and rising_edge[0]=1 for exactly one cycle, 6 edges after first capture; any_edge pulses in the same cycle; other channels stay 0.
- 3-cycle high glitch on signal_in[1] -> signal_out[1] stays 0, no pulses; a 4-cycle high then low pulse -> rising_edge[1], later falling_edge[1], one cycle each.
- signal_in 4'b0000->4'b1111 in one cycle -> rising_edge=4'b1111 in a single cycle, any_edge=1 once.
- rst_n dropped asynchronously 2 cycles into a debounce of channel 2 -> outputs 0 immediately, before the next clk edge; after release with input still 1, a full-latency rising_edge[2] occurs.
- EDGE_LATCH_EN defined: edge on channel 3 -> event_flags[3]=1 and held; event_clear[3] pulsed in the same cycle as a new rising_edge[3] -> flag remains 1; clear on a later idle cycle -> flag 0.
